positaccum_encode_16: RTL and testbench
=======================================

POSITACCUM_ENCODE_16 -- requirements
Module: positaccum_encode_16

Interface
REQ-001 The block SHALL expose parameter FBITS, default FBITS_ACCUM: width of the serialized accumulator fraction, hidden bit excluded.
REQ-002 The block SHALL expose port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL expose port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL expose port start, input, 1 bit: in1 and truncated_in valid this cycle; driven by the accumulator done.
REQ-005 The block SHALL expose port in1, input, FBITS+12 bits, serialized accumulator value: [FBITS+11] sgn; [FBITS+10:FBITS+2] scale, 9-bit two's complement; [FBITS+1:2] fraction, MSB-first; [1] inf; [0] zero.
REQ-006 The block SHALL expose port truncated_in, input, 1 bit: the accumulator discarded nonzero bits; it contributes to the sticky bit.
REQ-007 The block SHALL expose port result, output, 16 bits: encoded posit<16,2>.
REQ-008 The block SHALL expose port done, output, 1 bit: result is valid this cycle.
REQ-009 The block SHALL expose port inexact, output, 1 bit: guard or sticky was nonzero, or clamping occurred, for the value on result.

Function
REQ-010 The block SHALL be a 4-stage pipeline accepting one input per cycle, with no backpressure.
- Latency: start at cycle N -> done at cycle N+4.
- Back-to-back starts produce back-to-back dones, in order.
REQ-011 Stage 1 SHALL register the inputs and compute:
- k = scale >>> 2 (arithmetic, floor).
- e = scale[1:0].
- clamp flags: hi when scale > 56, lo when scale < -56.
REQ-012 Stage 2 SHALL form the unsigned magnitude string from regime, e[1:0] and fraction, then right-justify it to 15 bits plus guard plus sticky.
- Regime for k >= 0: k+1 ones followed by a 0.
- Regime for k < 0: -k zeros followed by a 1.
- sticky = OR of all remaining bits | truncated_in.
REQ-013 Stage 3 SHALL round to nearest, ties to even.
- Increment the 15-bit magnitude when guard & (lsb | sticky).
- Saturate the result to the range 0x0001..0x7FFF.
REQ-014 Stage 4 SHALL apply the special cases in this priority: inf -> 0x8000; zero -> 0x0000; clamp hi -> magnitude 0x7FFF; clamp lo -> magnitude 0x0001.
- A nonzero finite value never encodes as 0x0000 or 0x8000.
REQ-015 Stage 4 SHALL output {0, mag} when sgn = 0 and the 16-bit two's complement of {0, mag} when sgn = 1, except for the inf and zero cases.
REQ-016 inexact SHALL be 1 if guard | sticky | clamp hi | clamp lo, forced to 0 for the inf and zero cases.
REQ-017 result and inexact SHALL be registered, update only on cycles where the stage-4 valid is set, and otherwise hold their last value.
REQ-018 done SHALL be a registered copy of the stage-4 valid, high for exactly one cycle per accepted start.
REQ-019 An X on start SHALL be treated as 0.
REQ-020 When start = 0, in1 and truncated_in SHALL be ignored, and no state other than the valid chain SHALL change.

Reset
REQ-021 Asserting rst low SHALL immediately clear all stage valids, done, result (0x0000) and inexact (0).
REQ-022 Reset mid-operation SHALL discard all in-flight values; no done is produced for starts accepted before reset.
REQ-023 The first start sampled after rst deasserts SHALL produce done exactly 4 cycles later.

Verification
REQ-024 The bench SHALL cover exact values:
- scale 0, fraction 0, sgn 0 -> result 0x4000, inexact 0.
- sgn 1 -> 0xC000.
- scale 4 -> 0x6000.
REQ-025 The bench SHALL cover the rounding tie: scale 0, fraction with only bit FBITS-12 set (first bit below the 11 kept fraction bits).
- truncated_in 0 -> 0x4000, inexact 1.
- truncated_in 1 -> 0x4001.
REQ-026 The bench SHALL cover clamping and specials:
- scale 60 -> 0x7FFF.
- scale -60 -> 0x0001.
- scale 60, sgn 1 -> 0x8001.
- inf = 1 -> 0x8000.
- zero = 1 -> 0x0000.
REQ-027 The bench SHALL cover the stream: start high for 8 consecutive cycles with distinct values -> 8 consecutive done pulses starting 4 cycles later, results in order.
REQ-028 The bench SHALL cover reset mid-stream: rst low 2 cycles after 3 starts -> no done pulses, result 0x0000; the next start -> done 4 cycles later with the correct value.
REQ-029 The bench SHALL cover result hold: after a single done, start low for 10 cycles -> result and inexact unchanged, done 0.

Source files
------------

// File: rtl/positaccum_encode_16.sv
// Four-stage encoder from the serialized accumulator format to posit<16,2>.
// It applies round-to-nearest-even, saturation and clamping, and flags inexact results.
package positaccum_encode_16_pkg;
  localparam int FBITS_ACCUM = 32;
endpackage

module positaccum_encode_16
  import positaccum_encode_16_pkg::*;
#(
  parameter int FBITS = FBITS_ACCUM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [FBITS+11:0] in1,
  input  logic             truncated_in,
  output logic [15:0]      result,
  output logic             done,
  output logic             inexact
);

  // Layout of the stage-2 string: 16 regime pad bits, terminator, e[1:0], fraction.
  localparam int SW = FBITS + 3;
  localparam int EW = SW + 16;

  // ---------------- stage 1 decode ----------------
  logic              w_start;
  logic signed [8:0] w_scale;
  logic signed [8:0] w_k;

  // NOTE: the case-equality operator makes an X on start act as "no start" in simulation.
  assign w_start = (start === 1'b1);
  assign w_scale = in1[FBITS+10:FBITS+2];
  assign w_k     = w_scale >>> 2;

  logic              r_s1_valid, r_s2_valid, r_s3_valid;
  logic              r_s1_sgn, r_s1_inf, r_s1_zero, r_s1_hi, r_s1_lo, r_s1_trunc;
  logic signed [6:0] r_s1_k;
  logic [1:0]        r_s1_e;
  logic [FBITS-1:0]  r_s1_frac;

  logic              r_s2_sgn, r_s2_inf, r_s2_zero, r_s2_hi, r_s2_lo;
  logic [14:0]       r_s2_mag;
  logic              r_s2_guard, r_s2_sticky;

  logic              r_s3_sgn, r_s3_inf, r_s3_zero, r_s3_hi, r_s3_lo;
  logic [14:0]       r_s3_mag;
  logic              r_s3_gs;

  // ---------------- stage 2 regime placement ----------------
  logic [4:0]        w_run;
  logic [EW-1:0]     w_ext;
  logic [EW-1:0]     w_shifted;
  logic [14:0]       w_mag15;
  logic              w_guard, w_sticky;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_run = 5'd16;
    if (!r_s1_k[6]) begin
      if (r_s1_k < 7'sd15) w_run = 5'(r_s1_k + 7'sd1);
    end else begin
      if (r_s1_k > -7'sd16) w_run = 5'(-r_s1_k);
    end
  end

  // Regime run of (k+1) ones or (-k) zeros, then the terminator, e and fraction.
  assign w_ext     = {{16{~r_s1_k[6]}}, r_s1_k[6], r_s1_e, r_s1_frac};
  assign w_shifted = w_ext << (5'd16 - w_run);
  assign w_mag15   = w_shifted[EW-1 -: 15];
  assign w_guard   = w_shifted[EW-16];
  assign w_sticky  = (|w_shifted[EW-17:0]) | r_s1_trunc;

  // ---------------- stage 3 rounding ----------------
  logic        w_inc;
  logic [15:0] w_sum;
  logic [14:0] w_rnd;

  assign w_inc = r_s2_guard & (r_s2_mag[0] | r_s2_sticky);
  assign w_sum = {1'b0, r_s2_mag} + {15'd0, w_inc};

  always_comb begin
    w_rnd = w_sum[14:0];
    if (w_sum[15])          w_rnd = 15'h7FFF;
    else if (w_sum == '0)   w_rnd = 15'h0001;
  end

  // ---------------- stage 4 specials and sign ----------------
  logic [14:0] w_mag;
  logic [15:0] w_result;
  logic        w_inexact;

  always_comb begin
    w_mag     = r_s3_mag;
    w_inexact = r_s3_gs;
    if (r_s3_hi) begin
      w_mag     = 15'h7FFF;
      w_inexact = 1'b1;
    end else if (r_s3_lo) begin
      w_mag     = 15'h0001;
      w_inexact = 1'b1;
    end
    w_result = r_s3_sgn ? (16'd0 - {1'b0, w_mag}) : {1'b0, w_mag};
    if (r_s3_inf) begin
      w_result  = 16'h8000;
      w_inexact = 1'b0;
    end else if (r_s3_zero) begin
      w_result  = 16'h0000;
      w_inexact = 1'b0;
    end
  end

  // ---------------- control and output registers ----------------
  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
      done       <= 1'b0;
      result     <= 16'h0000;
      inexact    <= 1'b0;
    end else begin
      r_s1_valid <= w_start;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
      done       <= r_s3_valid;
      if (r_s3_valid) begin
        result  <= w_result;
        inexact <= w_inexact;
      end
    end
  end

  // NOTE: datapath registers carry no reset; the valid chain alone decides what is live.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_s1_sgn   <= in1[FBITS+11];
      r_s1_k     <= w_k[6:0];
      r_s1_e     <= w_scale[1:0];
      r_s1_frac  <= in1[FBITS+1:2];
      r_s1_inf   <= in1[1];
      r_s1_zero  <= in1[0];
      r_s1_trunc <= truncated_in;
      r_s1_hi    <= (w_scale > 9'sd56);
      r_s1_lo    <= (w_scale < -9'sd56);
    end
    if (r_s1_valid) begin
      r_s2_sgn    <= r_s1_sgn;
      r_s2_inf    <= r_s1_inf;
      r_s2_zero   <= r_s1_zero;
      r_s2_hi     <= r_s1_hi;
      r_s2_lo     <= r_s1_lo;
      r_s2_mag    <= w_mag15;
      r_s2_guard  <= w_guard;
      r_s2_sticky <= w_sticky;
    end
    if (r_s2_valid) begin
      r_s3_sgn  <= r_s2_sgn;
      r_s3_inf  <= r_s2_inf;
      r_s3_zero <= r_s2_zero;
      r_s3_hi   <= r_s2_hi;
      r_s3_lo   <= r_s2_lo;
      r_s3_mag  <= w_rnd;
      r_s3_gs   <= r_s2_guard | r_s2_sticky;
    end
  end

endmodule

// File: tb/tb_positaccum_encode_16.sv
// Self-checking bench for positaccum_encode_16: directed table, stream, random vs. model, hold, reset.
module tb_positaccum_encode_16;
  localparam int FB = 32;
  localparam int IW = FB + 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          truncated_in = 1'b0;
  logic [IW-1:0] in1 = '0;
  logic [15:0]   result;
  logic          done;
  logic          inexact;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  positaccum_encode_16 #(.FBITS(FB)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in1          (in1),
    .truncated_in (truncated_in),
    .result       (result),
    .done         (done),
    .inexact      (inexact)
  );

  typedef struct {
    bit            sgn;
    int            scale;
    logic [FB-1:0] frac;
    bit            inf;
    bit            zero;
    bit            trunc;
    logic [15:0]   exp_res;
    bit            exp_inx;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    bit          inx;
    int          due;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [IW-1:0] pack(input bit sgn, input int scale, input logic [FB-1:0] frac,
                                         input bit inf, input bit zero);
    logic [8:0] s9;
    s9 = 9'(scale);
    return {sgn, s9, frac, inf, zero};
  endfunction

  // Reference: builds the posit bit string as a list of bits, then rounds with integer arithmetic.
  function automatic void model(input logic [IW-1:0] v, input bit trunc,
                                output logic [15:0] res, output bit inx);
    bit q[$];
    int scale, k, e, mag;
    bit guard, sticky;
    scale = int'($signed(v[FB+10:FB+2]));
    inx = 1'b0;
    mag = 0;
    if (v[1]) begin
      res = 16'h8000;
      return;
    end
    if (v[0]) begin
      res = 16'h0000;
      return;
    end
    if (scale > 56) begin
      mag = 32767;
      inx = 1'b1;
    end else if (scale < -56) begin
      mag = 1;
      inx = 1'b1;
    end else begin
      k = (scale >= 0) ? scale / 4 : -((3 - scale) / 4);
      e = scale - 4 * k;
      if (k >= 0) begin
        repeat (k + 1) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        repeat (-k) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      q.push_back(bit'((e >> 1) & 1));
      q.push_back(bit'(e & 1));
      for (int i = FB - 1; i >= 0; i--) q.push_back(v[2+i]);
      for (int i = 0; i < 15; i++) mag = mag * 2 + int'(q[i]);
      guard  = q[15];
      sticky = trunc;
      for (int i = 16; i < q.size(); i++) sticky |= q[i];
      if (guard && ((mag % 2 == 1) || sticky)) mag++;
      if (mag > 32767) mag = 32767;
      if (mag < 1) mag = 1;
      inx = guard | sticky;
    end
    res = v[IW-1] ? 16'(-mag) : 16'(mag);
  endfunction

  function automatic logic [IW-1:0] rand_vec();
    int   scale;
    bit   inf, zero;
    scale = int'($urandom_range(140, 0)) - 70;
    inf   = ($urandom_range(15, 0) == 0);
    zero  = ($urandom_range(15, 0) == 0);
    return pack(1'($urandom), scale, FB'($urandom), inf, zero);
  endfunction

  // One isolated start; reports latency in cycles (-1 when done never arrives).
  task automatic send_one(input logic [IW-1:0] v, input bit trunc,
                          output logic [15:0] res, output bit inx, output int lat);
    int c;
    @(negedge clk);
    start = 1'b1;
    in1 = v;
    truncated_in = trunc;
    lat = -1;
    res = '0;
    inx = 1'b0;
    c = 0;
    while (lat < 0 && c < 12) begin
      @(negedge clk);
      c++;
      if (c == 1) start = 1'b0;
      if (done) begin
        lat = c;
        res = result;
        inx = inexact;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t          vecs[12];
    logic [FB-1:0] tie, tie_lsb;
    logic [15:0]   res, mres;
    bit            inx, minx;
    int            lat, dcount;
    logic [IW-1:0] v;
    bit            tr;
    exp_t          eq[$];
    exp_t          ex;

    tie = '0;
    tie[FB-12] = 1'b1;
    tie_lsb = tie;
    tie_lsb[FB-11] = 1'b1;
    vecs[0]  = '{0,   0, '0,      0, 0, 0, 16'h4000, 0};
    vecs[1]  = '{1,   0, '0,      0, 0, 0, 16'hC000, 0};
    vecs[2]  = '{0,   4, '0,      0, 0, 0, 16'h6000, 0};
    vecs[3]  = '{0,   0, tie,     0, 0, 0, 16'h4000, 1};
    vecs[4]  = '{0,   0, tie,     0, 0, 1, 16'h4001, 1};
    vecs[5]  = '{0,  60, '0,      0, 0, 0, 16'h7FFF, 1};
    vecs[6]  = '{0, -60, '0,      0, 0, 0, 16'h0001, 1};
    vecs[7]  = '{1,  60, '0,      0, 0, 0, 16'h8001, 1};
    vecs[8]  = '{0,   7, '0,      1, 0, 0, 16'h8000, 0};
    vecs[9]  = '{1,   7, '0,      0, 1, 1, 16'h0000, 0};
    vecs[10] = '{0,  -1, '0,      0, 0, 0, 16'h3800, 0};
    vecs[11] = '{0,   0, tie_lsb, 0, 0, 0, 16'h4002, 1};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_result", result, 16'h0000);
    check("reset_done", done, 0);
    check("reset_inexact", inexact, 0);
    rst = 1'b1;

    // Directed table; the first entry is also the first start after reset
    foreach (vecs[i]) begin
      send_one(pack(vecs[i].sgn, vecs[i].scale, vecs[i].frac, vecs[i].inf, vecs[i].zero),
               vecs[i].trunc, res, inx, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d_inexact", i), inx, vecs[i].exp_inx);
      check($sformatf("vec%0d_latency", i), lat, 4);
    end

    // Eight back-to-back starts
    dcount = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (done) begin
        check("stream_done_cycle", cyc, 4 + dcount);
        if (eq.size() > 0) begin
          ex = eq.pop_front();
          check($sformatf("stream%0d_result", dcount), result, ex.res);
          check($sformatf("stream%0d_inexact", dcount), inexact, ex.inx);
        end else begin
          check("stream_unexpected_done", done, 0);
        end
        dcount++;
      end
      if (cyc < 8) begin
        v  = pack(1'(cyc % 2), cyc * 3 - 10, FB'($urandom), 0, 0);
        tr = 1'($urandom);
        model(v, tr, mres, minx);
        eq.push_back('{mres, minx, cyc + 4});
        start = 1'b1;
        in1 = v;
        truncated_in = tr;
      end else begin
        start = 1'b0;
      end
    end
    check("stream_done_count", dcount, 8);
    eq.delete();

    // Randomized stream with gaps against the reference model
    for (int cyc = 0; cyc < 310; cyc++) begin
      @(negedge clk);
      if (done) begin
        if (eq.size() > 0) begin
          ex = eq.pop_front();
          check("rand_done_cycle", cyc, ex.due);
          check("rand_result", result, ex.res);
          check("rand_inexact", inexact, ex.inx);
        end else begin
          check("rand_spurious_done", done, 0);
        end
      end
      if (cyc < 300 && $urandom_range(3, 0) != 0) begin
        v  = rand_vec();
        tr = 1'($urandom);
        model(v, tr, mres, minx);
        eq.push_back('{mres, minx, cyc + 4});
        start = 1'b1;
        in1 = v;
        truncated_in = tr;
      end else begin
        start = 1'b0;
        in1 = rand_vec();
        truncated_in = 1'($urandom);
      end
    end
    check("rand_all_done", eq.size(), 0);
    eq.delete();

    // Result hold while idle, with inputs wiggling
    send_one(pack(0, 0, tie, 0, 0), 1'b1, res, inx, lat);
    check("hold_first_result", res, 16'h4001);
    check("hold_first_inexact", inx, 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in1 = rand_vec();
      truncated_in = 1'($urandom);
      check("hold_result", result, 16'h4001);
      check("hold_inexact", inexact, 1);
      check("hold_done", done, 0);
    end

    // Reset in the middle of a stream
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      start = 1'b1;
      in1 = pack(0, c * 4, '0, 0, 0);
      truncated_in = 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_result", result, 16'h0000);
    check("midrst_inexact", inexact, 0);
    check("midrst_done", done, 0);
    dcount = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 1) rst = 1'b1;
      if (done) dcount++;
    end
    check("midrst_no_done", dcount, 0);
    check("midrst_result_after", result, 16'h0000);
    v = pack(1, 5, FB'($urandom), 0, 0);
    model(v, 1'b0, mres, minx);
    send_one(v, 1'b0, res, inx, lat);
    check("post_rst_latency", lat, 4);
    check("post_rst_result", res, mres);
    check("post_rst_inexact", inx, minx);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
